// File: rtl/cdc_pkt_buffer_if.sv
// Valid/ready word stream with end-of-packet marker.
// The master drives the data and the slave drives tready.
interface cdc_pkt_buffer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cdc_pkt_buffer.sv
// Store-and-forward packet buffer feeding a CDC crossing: a packet becomes readable only
// once its last word is stored, and packets longer than DEPTH are discarded whole.
module cdc_pkt_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    cdc_pkt_buffer_if.slave          s,
    cdc_pkt_buffer_if.master         m,
    output logic [$clog2(DEPTH):0]   pkt_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic {ACCEPT, DISCARD} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]     pkt_cnt_reg;
    logic              drop_reg, drop_next;
    logic [DATA_W:0]   mem [DEPTH];

    logic [PW-1:0]     level_w, uncommitted;
    logic              s_ready, wr_en, rd_en, overflow;
    logic              m_valid;
    logic [DATA_W:0]   rd_word;

    assign level_w     = wr_ptr_reg - rd_ptr_reg;
    assign uncommitted = wr_ptr_reg - commit_ptr_reg;
    assign m_valid     = (rd_ptr_reg != commit_ptr_reg);
    assign rd_word     = mem[rd_ptr_reg[AW-1:0]];
    assign rd_en       = m_valid && m.tready;

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        overflow   = 1'b0;
        drop_next  = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            ACCEPT: begin
                s_ready = (level_w != DEPTH_P);
                wr_en   = s.tvalid && s_ready;
                // Memory filled by a single unterminated packet: it can never commit.
                if (uncommitted == DEPTH_P) begin
                    overflow   = 1'b1;
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                s_ready = 1'b1;
                if (s.tvalid && s.tlast) begin
                    drop_next  = 1'b1;
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ACCEPT;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            pkt_cnt_reg    <= '0;
            drop_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
            if (overflow) begin
                wr_ptr_reg <= commit_ptr_reg;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (wr_en && s.tlast) begin
                commit_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en && s.tlast, rd_en && rd_word[DATA_W]})
                2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
                2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
                default: pkt_cnt_reg <= pkt_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= {s.tlast, s.tdata};
        end
    end

    assign s.tready = s_ready;
    assign m.tvalid = m_valid;
    assign m.tdata  = rd_word[DATA_W-1:0];
    assign m.tlast  = rd_word[DATA_W];
    assign pkt_cnt  = pkt_cnt_reg;
    assign level    = level_w;
    assign drop     = drop_reg;
endmodule

// File: tb/tb_cdc_pkt_buffer.sv
// Self-checking bench for cdc_pkt_buffer: a scoreboard queue holds the words expected on
// the master side; scenario tasks drive packets and check flags inline.
module tb_cdc_pkt_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] pkt_cnt, level;
    logic          drop;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] sb[$];
    logic [DATA_W:0] mon_exp;

    always #5 clk = ~clk;

    cdc_pkt_buffer_if #(.DATA_W(DATA_W)) s_bus();
    cdc_pkt_buffer_if #(.DATA_W(DATA_W)) m_bus();

    cdc_pkt_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .s       (s_bus),
        .m       (m_bus),
        .pkt_cnt (pkt_cnt),
        .level   (level),
        .drop    (drop)
    );

    // Inputs change only just after posedge, so a handshake seen here completes at the next posedge.
    always @(negedge clk) begin
        if (aresetn && m_bus.tvalid && m_bus.tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h last=%b, required no output", m_bus.tdata, m_bus.tlast);
            end else begin
                mon_exp = sb.pop_front();
                if ({m_bus.tlast, m_bus.tdata} !== mon_exp)
                    begin
                        errors++;
                        $display("FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                                 m_bus.tlast, m_bus.tdata, mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
                    end
                else
                    $display("rd data=%h last=%b", m_bus.tdata, m_bus.tlast);
            end
        end
    end

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        int n;
        s_bus.tdata  = d;
        s_bus.tlast  = l;
        s_bus.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_bus.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_bus.tready) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got s_tready=0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        s_bus.tvalid = 1'b0;
        s_bus.tlast  = 1'b0;
        $display("wr data=%h last=%b", d, l);
    endtask

    task automatic send_pkt(input int len, input int base, input int step, input bit push);
        logic [DATA_W-1:0] d;
        logic              l;
        for (int i = 0; i < len; i++) begin
            d = DATA_W'(base + i * step);
            l = (i == len - 1);
            if (push) sb.push_back({l, d});
            send_word(d, l);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words still expected, required 0", name, sb.size());
        end
        checks++;
        if (m_bus.tvalid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL %s_empty: got m_tvalid=%b level=%0d, required 0 and 0", name, m_bus.tvalid, level);
        end
    endtask

    task automatic test_reset();
        aresetn      = 1'b0;
        s_bus.tvalid = 1'b0;
        s_bus.tlast  = 1'b0;
        s_bus.tdata  = '0;
        m_bus.tready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pkt_cnt !== '0 || level !== '0 || drop !== 1'b0 || m_bus.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pkt_cnt=%0d level=%0d drop=%b m_tvalid=%b, required all 0",
                     pkt_cnt, level, drop, m_bus.tvalid);
        end
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_bus.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got s_tready=%b, required 1", s_bus.tready);
        end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] d;
        m_bus.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'(8'h11 * (i + 1));
            sb.push_back({(i == 2), d});
            send_word(d, (i == 2));
            if (i < 2) begin
                checks++;
                if (m_bus.tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: got m_tvalid=%b after word %0d, required 0", m_bus.tvalid, i + 1);
                end
            end
        end
        checks++;
        if (m_bus.tvalid !== 1'b1 || pkt_cnt !== PW'(1)) begin
            errors++;
            $display("FAIL single_commit: got m_tvalid=%b pkt_cnt=%0d, required 1 and 1", m_bus.tvalid, pkt_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (m_bus.tvalid !== 1'b1) begin
                errors++;
                $display("FAIL single_burst: got m_tvalid=%b on read cycle %0d, required 1", m_bus.tvalid, k);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_cnt !== '0 || m_bus.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got pkt_cnt=%0d m_tvalid=%b, required 0 and 0", pkt_cnt, m_bus.tvalid);
        end
    endtask

    task automatic test_fill();
        m_bus.tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(4, 8'h40 + 16 * p, 1, 1'b1);
        @(negedge clk);
        checks++;
        if (level !== PW'(16) || pkt_cnt !== PW'(4) || s_bus.tready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got level=%0d pkt_cnt=%0d s_tready=%b, required 16 4 0",
                     level, pkt_cnt, s_bus.tready);
        end
        m_bus.tready = 1'b1;
        wait_drain("fill");
        checks++;
        if (s_bus.tready !== 1'b1 || pkt_cnt !== '0) begin
            errors++;
            $display("FAIL fill_ready: got s_tready=%b pkt_cnt=%0d, required 1 and 0", s_bus.tready, pkt_cnt);
        end
    endtask

    task automatic test_overflow();
        m_bus.tready = 1'b1;
        for (int i = 0; i < 16; i++) send_word(DATA_W'(8'hA0 + i), 1'b0);
        checks++;
        if (s_bus.tready !== 1'b0 || level !== PW'(16)) begin
            errors++;
            $display("FAIL ovf_full: got s_tready=%b level=%0d, required 0 and 16", s_bus.tready, level);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_bus.tready !== 1'b1 || level !== '0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL ovf_discard: got s_tready=%b level=%0d drop=%b, required 1 0 0", s_bus.tready, level, drop);
        end
        for (int i = 16; i < 20; i++) send_word(DATA_W'(8'hA0 + i), (i == 19));
        checks++;
        if (drop !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: got drop=%b after last word, required 1", drop);
        end
        @(posedge clk);
        #1;
        checks++;
        if (drop !== 1'b0 || m_bus.tvalid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL ovf_after: got drop=%b m_tvalid=%b level=%0d, required 0 0 0", drop, m_bus.tvalid, level);
        end
        send_pkt(2, 8'h5A, 1, 1'b1);
        wait_drain("ovf_next");
    endtask

    task automatic test_exact();
        m_bus.tready = 1'b0;
        send_pkt(16, 8'h80, 3, 1'b1);
        checks++;
        if (pkt_cnt !== PW'(1) || level !== PW'(16)) begin
            errors++;
            $display("FAIL exact_commit: got pkt_cnt=%0d level=%0d, required 1 and 16", pkt_cnt, level);
        end
        @(posedge clk);
        #1;
        checks++;
        if (drop !== 1'b0 || level !== PW'(16) || m_bus.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL exact_kept: got drop=%b level=%0d m_tvalid=%b, required 0 16 1", drop, level, m_bus.tvalid);
        end
        m_bus.tready = 1'b1;
        wait_drain("exact");
    endtask

    task automatic test_back_to_back();
        m_bus.tready = 1'b0;
        send_pkt(2, 8'hC1, 1, 1'b1);
        m_bus.tready = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({1'b1, 8'hD7});
        send_word(8'hD7, 1'b1);
        checks++;
        if (pkt_cnt !== PW'(1) || m_bus.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cnt: got pkt_cnt=%0d m_tvalid=%b, required 1 and 1", pkt_cnt, m_bus.tvalid);
        end
        wait_drain("b2b");
    endtask

    task automatic test_async_reset();
        m_bus.tready = 1'b0;
        send_pkt(2, 8'h21, 1, 1'b1);
        send_pkt(2, 8'h31, 1, 1'b1);
        s_bus.tdata  = 8'h99;
        s_bus.tlast  = 1'b0;
        s_bus.tvalid = 1'b1;
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (pkt_cnt !== '0 || level !== '0 || m_bus.tvalid !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: got pkt_cnt=%0d level=%0d m_tvalid=%b drop=%b, required all 0",
                     pkt_cnt, level, m_bus.tvalid, drop);
        end
        sb.delete();
        s_bus.tvalid = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_exact();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cdc_pkt_buffer.md
# cdc_pkt_buffer

Single-clock store-and-forward packet buffer sitting directly upstream of the CDC crossing: it accepts a valid/ready word stream with end-of-packet markers and releases a packet to the crossing only after its last word has been stored. Packets longer than the buffer are discarded whole, so the crossing never sees a partial packet. The verification environment drives its slave side with packets and observes its master side as the CDC source.

## Interface
- DATA_W, 8, payload width in bits
- DEPTH, 16, storage words; power of two, >= 4; also the maximum accepted packet length
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  DATA_W  upstream word
- s_tvalid  in  1  upstream word valid
- s_tlast  in  1  upstream last word of packet
- s_tready  out  1  buffer can take a word
- m_tdata  out  DATA_W  word to CDC stage
- m_tvalid  out  1  word valid toward CDC stage
- m_tlast  out  1  last word of packet toward CDC stage
- m_tready  in  1  CDC stage accepts the word
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored
- level  out  $clog2(DEPTH)+1  words stored, committed plus uncommitted
- drop  out  1  one-cycle pulse when an oversize packet finishes being discarded

## Operation
- Memory: DEPTH entries of {tlast, tdata}. Pointers wr_ptr, commit_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; the memory index is the low bits.
- level = wr_ptr - rd_ptr. Uncommitted words: wr_ptr - commit_ptr.
- Write handshake: s_tvalid && s_tready. It stores the word and increments wr_ptr. If s_tlast is set, commit_ptr <= wr_ptr+1 and pkt_cnt increments.
- Read: m_tvalid = (rd_ptr != commit_ptr). m_tdata/m_tlast are read directly from mem[rd_ptr] (first-word fall-through). A read handshake increments rd_ptr; if m_tlast is set, pkt_cnt decrements.
- If a tlast write and a tlast read occur in the same cycle, pkt_cnt is unchanged.
- FSM states: ACCEPT and DISCARD.
  - ACCEPT: s_tready = (level != DEPTH). If (wr_ptr - commit_ptr) == DEPTH, which means the memory is completely filled by one unterminated packet, then on the next edge wr_ptr <= commit_ptr and the state goes to DISCARD.
  - DISCARD: s_tready = 1 and accepted words are not stored. A handshake with s_tlast raises drop for one cycle and returns the state to ACCEPT.
- A packet of exactly DEPTH words, with tlast on word DEPTH, commits normally and is not dropped.
- Reads continue unaffected during DISCARD. Committed data is never disturbed by a discard.

## Timing
- Reset (asynchronous, aresetn low): all pointers 0, state ACCEPT, pkt_cnt 0, level 0, drop 0, m_tvalid 0. s_tready is 1 whenever reset is deasserted and the buffer is empty. Reset mid-packet loses all stored and partial data.
- Packet latency: m_tvalid rises on the cycle after the cycle in which tlast is accepted. Word throughput is 1 per cycle on both sides.
- s_tready is combinational from state and pointers only; it never depends on s_tvalid.
- m_tvalid is combinational from pointers only; it never depends on m_tready.
- Once m_tvalid is high it stays high, with m_tdata stable, until a handshake occurs.
- Overflow sequence: the cycle after the DEPTH-th non-last word is accepted, s_tready = 0 and level = DEPTH. On the following cycle the state is DISCARD, level drops back to the committed count, and s_tready = 1.
- drop is high in the cycle after the discarded tlast handshake.

## Test plan
- Single 3-word packet 0x11,0x22,0x33 with m_tready=1 -> m_tvalid stays 0 until the cycle after 0x33 is accepted; the three words appear on consecutive cycles; m_tlast is set only on 0x33; pkt_cnt goes 0→1→0.
- m_tready=0, four 4-word packets at DEPTH=16 -> level=16, pkt_cnt=4, s_tready=0; then m_tready=1 -> all 16 words drain in order with m_tlast on words 4, 8, 12 and 16; s_tready returns to 1.
- 20-word packet into an empty DEPTH=16 buffer -> s_tready low for exactly one cycle after word 16, then DISCARD; drop pulses once after word 20; m_tvalid stays 0 and level ends at 0; a following 2-word packet passes intact.
- A 16-word packet into an empty DEPTH=16 buffer -> committed, pkt_cnt=1, no drop; all 16 words are read out.
- With one packet stored, a tlast read and a tlast write of a new 1-word packet occur in the same cycle -> pkt_cnt stays 1 and the new word follows with correct data.
- aresetn pulsed low mid-write with 2 packets stored -> immediately pkt_cnt=0, level=0, m_tvalid=0, drop=0; after release, a 3-word packet behaves exactly as in the first scenario.
